// File: rtl/keccak_round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : keccak_round_sequencer_if
// Brief    : Host and step-unit signal bundle for the Keccak round sequencer.
// Revision : 1.0
// ============================================================================
interface keccak_round_sequencer_if #(
    parameter int STATE_W = 1600
);
    logic                   start;
    logic [STATE_W-1:0]     state_in;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [STATE_W-1:0]     state_out;
    logic [4:0]             step_start;
    logic [STATE_W-1:0]     step_state;
    logic [4:0]             round_idx;
    logic [4:0]             step_done;
    logic [5*STATE_W-1:0]   step_result;

    // The sequencer is the master: it owns the state and drives the step units.
    modport master (
        input  start, state_in, step_done, step_result,
        output busy, done, err, state_out, step_start, step_state, round_idx
    );

    modport slave (
        output start, state_in, step_done, step_result,
        input  busy, done, err, state_out, step_start, step_state, round_idx
    );
endinterface
`default_nettype wire

// File: rtl/keccak_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : keccak_round_sequencer
// Brief    : Runs theta/rho/pi/chi/iota step units over NUM_ROUNDS rounds.
// Revision : 1.0
// ============================================================================
module keccak_round_sequencer #(
    parameter int STATE_W    = 1600,
    parameter int NUM_ROUNDS = 24,
    parameter int STEP_TMO   = 15
) (
    input  wire logic                clk,
    input  wire logic                rst,
    keccak_round_sequencer_if.master bus
);
    localparam int                 c_TMO_W      = $clog2(STEP_TMO + 1);
    localparam logic [4:0]         c_LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [2:0]         c_LAST_STEP  = 3'd4;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(STEP_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t               r_fsm;
    logic [STATE_W-1:0]   r_work;
    logic [STATE_W-1:0]   r_state_out;
    logic [2:0]           r_step;
    logic [4:0]           r_round;
    logic [c_TMO_W-1:0]   r_tmo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [4:0]           r_step_start;

    logic [STATE_W-1:0]   w_slice [5];
    logic [4:0]           w_expect;
    logic                 w_hit;
    logic                 w_wrong;

    genvar k;
    generate
        for (k = 0; k < 5; k++) begin : g_slice
            assign w_slice[k] = bus.step_result[k*STATE_W +: STATE_W];
        end
    endgenerate

    assign w_expect = 5'b00001 << r_step;
    assign w_hit    = |(bus.step_done & w_expect);
    assign w_wrong  = |(bus.step_done & ~w_expect);

    // step_start is set on entry to ISSUE so it is high for exactly that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm        <= S_IDLE;
            r_work       <= '0;
            r_state_out  <= '0;
            r_step       <= '0;
            r_round      <= '0;
            r_tmo        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_step_start <= '0;
        end else begin
            r_step_start <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (bus.start) begin
                        r_work       <= bus.state_in;
                        r_step       <= '0;
                        r_round      <= '0;
                        r_busy       <= 1'b1;
                        r_step_start <= 5'b00001;
                        r_fsm        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmo <= '0;
                    r_fsm <= S_WAIT;
                end
                S_WAIT: begin
                    // A done from the wrong unit wins over the expected one.
                    if (w_wrong) begin
                        r_err <= 1'b1;
                        r_fsm <= S_ERR;
                    end else if (w_hit) begin
                        r_work <= w_slice[r_step];
                        if (r_step != c_LAST_STEP) begin
                            r_step       <= r_step + 3'd1;
                            r_step_start <= w_expect << 1;
                            r_fsm        <= S_ISSUE;
                        end else if (r_round < c_LAST_ROUND) begin
                            r_round      <= r_round + 5'd1;
                            r_step       <= '0;
                            r_step_start <= 5'b00001;
                            r_fsm        <= S_ISSUE;
                        end else begin
                            r_state_out <= w_slice[r_step];
                            r_done      <= 1'b1;
                            r_fsm       <= S_FINISH;
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_err <= 1'b1;
                        r_fsm <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_FINISH, S_ERR: begin
                    r_busy <= 1'b0;
                    r_fsm  <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.state_out  = r_state_out;
    assign bus.step_start = r_step_start;
    assign bus.step_state = r_work;
    assign bus.round_idx  = r_round;

endmodule
`default_nettype wire

// File: tb/tb_keccak_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_keccak_round_sequencer
// Brief    : Randomised bench with Keccak step-unit models and a permutation model.
// Revision : 1.0
// ============================================================================
module tb_keccak_round_sequencer;
    localparam int c_W         = 1600;
    localparam int c_NR        = 24;
    localparam int c_TMO       = 15;
    localparam int c_NSTEPS    = 5 * c_NR;
    localparam int c_TMO_IDX   = 3 * 5 + 1;

    logic clk = 1'b0;
    logic rst;

    keccak_round_sequencer_if #(.STATE_W(c_W)) bus ();

    keccak_round_sequencer #(
        .STATE_W    (c_W),
        .NUM_ROUNDS (c_NR),
        .STEP_TMO   (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int dly [c_NSTEPS];
    int fault_kind = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_wide(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        int lane;
        checks++;
        if (act !== exp) begin
            errors++;
            lane = 0;
            for (int i = 24; i >= 0; i--)
                if (act[64*i +: 64] !== exp[64*i +: 64]) lane = i;
            $display("FAIL %s: lane %0d got %h expected %h (cycle %0d)",
                     name, lane, act[64*lane +: 64], exp[64*lane +: 64], cyc);
        end
    endtask

    // ---------------- Keccak reference ----------------
    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        int m;
        m = n % 64;
        return (m == 0) ? x : ((x << m) | (x >> (64 - m)));
    endfunction

    function automatic logic rc_bit(input int t);
        logic [8:0] r;
        r = 9'h001;
        for (int i = 0; i < t % 255; i++) begin
            r = r << 1;
            if (r[8]) r = r ^ 9'h171;
        end
        return r[0];
    endfunction

    function automatic logic [63:0] round_const(input int rnd);
        logic [63:0] rc;
        rc = '0;
        for (int j = 0; j < 7; j++) rc[(1 << j) - 1] = rc_bit(j + 7 * rnd);
        return rc;
    endfunction

    function automatic logic [c_W-1:0] step_fn(input int k, input logic [c_W-1:0] s, input int rnd);
        logic [63:0] a [25];
        logic [63:0] b [25];
        logic [63:0] c [5];
        logic [63:0] d;
        int          off [25];
        int          x, y, t, nx;
        logic [c_W-1:0] res;
        for (int i = 0; i < 25; i++) begin
            a[i] = s[64*i +: 64];
            b[i] = a[i];
        end
        case (k)
            0: begin
                for (int xi = 0; xi < 5; xi++)
                    c[xi] = a[xi] ^ a[xi+5] ^ a[xi+10] ^ a[xi+15] ^ a[xi+20];
                for (int xi = 0; xi < 5; xi++) begin
                    d = c[(xi+4)%5] ^ rotl(c[(xi+1)%5], 1);
                    for (int yi = 0; yi < 5; yi++) b[xi+5*yi] = a[xi+5*yi] ^ d;
                end
            end
            1: begin
                off[0] = 0;
                x = 1; y = 0;
                for (t = 0; t < 24; t++) begin
                    off[x+5*y] = ((t+1)*(t+2)/2) % 64;
                    nx = y;
                    y  = (2*x + 3*y) % 5;
                    x  = nx;
                end
                for (int i = 0; i < 25; i++) b[i] = rotl(a[i], off[i]);
            end
            2: begin
                for (int xi = 0; xi < 5; xi++)
                    for (int yi = 0; yi < 5; yi++)
                        b[yi + 5*((2*xi + 3*yi) % 5)] = a[xi + 5*yi];
            end
            3: begin
                for (int xi = 0; xi < 5; xi++)
                    for (int yi = 0; yi < 5; yi++)
                        b[xi+5*yi] = a[xi+5*yi] ^ (~a[(xi+1)%5+5*yi] & a[(xi+2)%5+5*yi]);
            end
            4: b[0] = a[0] ^ round_const(rnd);
            default: ;
        endcase
        for (int i = 0; i < 25; i++) res[64*i +: 64] = b[i];
        return res;
    endfunction

    function automatic logic [c_W-1:0] f1600(input logic [c_W-1:0] s);
        logic [c_W-1:0] v;
        v = s;
        for (int r = 0; r < c_NR; r++)
            for (int k = 0; k < 5; k++) v = step_fn(k, v, r);
        return v;
    endfunction

    function automatic logic [c_W-1:0] rand_state();
        logic [c_W-1:0] s;
        for (int i = 0; i < c_W/32; i++) s[32*i +: 32] = $urandom();
        return s;
    endfunction

    task automatic set_delays(input int random_mode);
        for (int i = 0; i < c_NSTEPS; i++)
            dly[i] = random_mode ? int'($urandom_range(c_TMO - 1, 1)) : 1;
    endtask

    // ---------------- step-unit models ----------------
    initial begin : unit_model
        logic           job_active;
        int             job_cnt, job_k, job_bit, sidx;
        logic           job_silent;
        logic [c_W-1:0] job_res;
        job_active = 1'b0;
        job_cnt = 0; job_k = 0; job_bit = 0; job_silent = 1'b0; job_res = '0;
        bus.step_done   = '0;
        bus.step_result = '0;
        forever begin
            @(negedge clk);
            bus.step_done = '0;
            if (rst) begin
                job_active = 1'b0;
            end else begin
                if (job_active) begin
                    job_cnt--;
                    if (job_cnt == 0) begin
                        job_active = 1'b0;
                        if (!job_silent) begin
                            bus.step_result[job_k*c_W +: c_W] = job_res;
                            bus.step_done[job_bit] = 1'b1;
                        end
                    end
                end
                if (bus.step_start != 5'd0) begin
                    job_k = 0;
                    for (int k = 0; k < 5; k++) if (bus.step_start[k]) job_k = k;
                    sidx = 5 * int'(bus.round_idx) + job_k;
                    if (sidx >= c_NSTEPS) sidx = c_NSTEPS - 1;
                    job_res    = step_fn(job_k, bus.step_state, int'(bus.round_idx));
                    job_cnt    = dly[sidx];
                    job_bit    = job_k;
                    job_silent = 1'b0;
                    if (fault_kind == 1 && sidx == c_TMO_IDX) job_silent = 1'b1;
                    if (fault_kind == 2 && sidx == 0) job_bit = 2;
                    job_active = 1'b1;
                end
            end
        end
    end

    // ---------------- cycle-level compare against the schedule model ----------------
    initial begin : compare
        logic           m_busy, m_fault, s_start, s_rst;
        int             m_E, m_idle_from, m_next, m_idx, m_kf, acc;
        logic [c_W-1:0] m_out, m_expect, m_work, s_in;
        logic           exp_done, exp_err;
        logic [4:0]     exp_ss;
        m_busy = 1'b0; m_fault = 1'b0; m_E = 0; m_idle_from = 0;
        m_next = -1; m_idx = 0; m_kf = -1; m_out = '0; m_expect = '0; m_work = '0;
        forever begin
            @(posedge clk);
            cyc++;
            s_start = bus.start;
            s_in    = bus.state_in;
            s_rst   = rst;
            #1;
            if (s_rst || rst) begin
                m_busy = 1'b0; m_idle_from = 0; m_out = '0; m_next = -1;
                chk("rst_busy", 64'(bus.busy), 64'd0);
                chk("rst_done", 64'(bus.done), 64'd0);
                chk("rst_err", 64'(bus.err), 64'd0);
                chk("rst_step_start", 64'(bus.step_start), 64'd0);
                chk_wide("rst_state_out", bus.state_out, '0);
            end else begin
                if (!m_busy && cyc >= m_idle_from && s_start) begin
                    m_busy  = 1'b1;
                    m_kf    = (fault_kind == 1) ? c_TMO_IDX : (fault_kind == 2) ? 0 : -1;
                    m_fault = 1'b0;
                    acc     = cyc;
                    m_E     = -1;
                    for (int i = 0; i < c_NSTEPS; i++) begin
                        if (i == m_kf) begin
                            m_E = acc + 1 + ((fault_kind == 1) ? c_TMO : dly[i]);
                            m_fault = 1'b1;
                            break;
                        end
                        acc += 1 + dly[i];
                    end
                    if (!m_fault) m_E = acc;
                    m_expect = f1600(s_in);
                    m_work   = s_in;
                    m_next   = cyc;
                    m_idx    = 0;
                end
                exp_done = m_busy && (cyc == m_E) && !m_fault;
                exp_err  = m_busy && (cyc == m_E) && m_fault;
                if (exp_done) m_out = m_expect;
                exp_ss = '0;
                if (m_busy && cyc == m_next) begin
                    exp_ss = 5'(1 << (m_idx % 5));
                    chk("round_idx", 64'(bus.round_idx), 64'(m_idx / 5));
                    chk_wide("step_state", bus.step_state, m_work);
                    m_work = step_fn(m_idx % 5, m_work, m_idx / 5);
                    if (m_idx == m_kf || m_idx == c_NSTEPS - 1) m_next = -1;
                    else m_next += 1 + dly[m_idx];
                    m_idx++;
                end
                chk("busy", 64'(bus.busy), 64'(m_busy));
                chk("done", 64'(bus.done), 64'(exp_done));
                chk("err", 64'(bus.err), 64'(exp_err));
                chk("step_start", 64'(bus.step_start), 64'(exp_ss));
                chk_wide("state_out", bus.state_out, m_out);
                if (m_busy && cyc == m_E) begin
                    m_busy = 1'b0;
                    m_idle_from = cyc + 2;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic run_perm(input logic [c_W-1:0] st, input int bound,
                            output int lat, output logic got_done, output logic got_err);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.state_in = st;
        lat = -1; got_done = 1'b0; got_err = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.state_in = rand_state();
            if (bus.done || bus.err) begin
                lat = i - 1; got_done = bus.done; got_err = bus.err;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL perm_wait: no done or err within %0d cycles", bound);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : main
        logic [c_W-1:0] pin;
        int   lat, n, last_done, spacing_idx;
        int   done_at [3];
        logic gd, ge;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.state_in = '0;
        set_delays(0);

        pin = f1600('0);
        chk("model_f1600_zero_lane0", pin[63:0], 64'hF1258F7940E1DDE7);
        pin[63:0] = round_const(23);
        chk("model_rc23", pin[63:0], 64'h8000000080008008);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single-cycle units, zero state.
        run_perm('0, 400, lat, gd, ge);
        chk("t1_latency", 64'(lat), 64'd240);
        chk("t1_done", 64'(gd), 64'd1);
        chk("t1_lane0", bus.state_out[63:0], 64'hF1258F7940E1DDE7);
        @(negedge clk);
        chk("t1_busy_after", 64'(bus.busy), 64'd0);

        // Variable done delays.
        set_delays(1);
        run_perm('0, 2500, lat, gd, ge);
        chk("t2_done", 64'(gd), 64'd1);
        chk("t2_lane0", bus.state_out[63:0], 64'hF1258F7940E1DDE7);
        run_perm(rand_state(), 2500, lat, gd, ge);
        chk("t2_rand_done", 64'(gd), 64'd1);

        // rho silent in round 3.
        fault_kind = 1;
        set_delays(1);
        run_perm(rand_state(), 2500, lat, gd, ge);
        chk("t3_err", 64'(ge), 64'd1);
        @(negedge clk);
        chk("t3_busy_after", 64'(bus.busy), 64'd0);
        fault_kind = 0;
        run_perm(rand_state(), 2500, lat, gd, ge);
        chk("t3_recover_done", 64'(gd), 64'd1);

        // pi answers while theta is pending.
        fault_kind = 2;
        set_delays(0);
        run_perm(rand_state(), 50, lat, gd, ge);
        chk("t4_err", 64'(ge), 64'd1);
        chk("t4_latency", 64'(lat), 64'd2);
        fault_kind = 0;

        // start held high: back-to-back runs.
        @(negedge clk);
        bus.start = 1'b1;
        spacing_idx = 0;
        last_done = 0;
        for (int i = 0; i < 1000 && spacing_idx < 3; i++) begin
            @(negedge clk);
            bus.state_in = rand_state();
            if (bus.done) begin
                done_at[spacing_idx] = i;
                spacing_idx++;
            end
        end
        bus.start = 1'b0;
        chk("t5_done_count", 64'(spacing_idx), 64'd3);
        chk("t5_spacing_a", 64'(done_at[1] - done_at[0]), 64'd242);
        chk("t5_spacing_b", 64'(done_at[2] - done_at[1]), 64'd242);
        repeat (2) @(negedge clk);

        // Asynchronous reset in round 10.
        set_delays(1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.state_in = rand_state();
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.round_idx != 5'd10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_round10", 64'(bus.round_idx), 64'd10);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_round_idx", 64'(bus.round_idx), 64'd0);
        chk("t6_step_start", 64'(bus.step_start), 64'd0);
        chk_wide("t6_state_out", bus.state_out, '0);
        chk_wide("t6_step_state", bus.step_state, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_delays(0);
        run_perm(rand_state(), 400, lat, gd, ge);
        chk("t6_after_done", 64'(gd), 64'd1);
        chk("t6_after_latency", 64'(lat), 64'd240);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
